// File: rtl/systolic_array_3x3_pkg.sv
// Shared constants for the 3x3 convolution tile.
//   DATA_W   : width of every operand and result
//   ACC_W    : partial-sum width, wide enough for 9*255*255
//   N_PE     : number of chained MAC elements (one per filter tap)
//   N_WIN    : number of 3x3 windows in a 4x4 input (2x2 output)
//   DONE_CNT : step count at which all results are loaded
//   WIN_MAP  : WIN_MAP[w][k] = row-major input index (0..15) that window w
//              feeds to PE k. Window w sits at row w/2, col w%2; PE k is tap
//              (k/3, k%3), so the index is (w/2 + k/3)*4 + (w%2 + k%3).
package systolic_array_3x3_pkg;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 20;
    localparam int N_PE   = 9;
    localparam int N_WIN  = 4;
    localparam int N_MAT  = 16;
    localparam int CNT_W  = 4;
    localparam logic [CNT_W-1:0] DONE_CNT = 4'd14;

    // One 36-bit nibble string per window, PE 8 in the top nibble.
    localparam logic [N_WIN-1:0][N_PE-1:0][3:0] WIN_MAP = {
        36'hfedba9765,   // window 3 (result22)
        36'hedca98654,   // window 2 (result21)
        36'hba9765321,   // window 1 (result12)
        36'ha98654210    // window 0 (result11)
    };
endpackage

// File: rtl/systolic_array_3x3_pe.sv
// Weight-stationary MAC element.
//   clk, rst : clock and synchronous active-high reset
//   load     : capture weight into the stationary register
//   weight   : filter coefficient to hold
//   x        : input operand for this cycle (0 when no window is present)
//   psum_in  : partial sum from the previous PE (0 for the first PE)
//   psum_out : registered psum_in + weight * x
module systolic_pe
    import systolic_array_3x3_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] weight,
    input  logic [DATA_W-1:0] x,
    input  logic [ACC_W-1:0]  psum_in,
    output logic [ACC_W-1:0]  psum_out
);
    logic [DATA_W-1:0]   w_q;
    logic [2*DATA_W-1:0] prod;

    assign prod = {{DATA_W{1'b0}}, w_q} * {{DATA_W{1'b0}}, x};

    always_ff @(posedge clk) begin
        if (rst) begin
            w_q      <= '0;
            psum_out <= '0;
        end else begin
            if (load) w_q <= weight;
            psum_out <= psum_in + ACC_W'(prod);
        end
    end
endmodule

// File: rtl/systolic_array_3x3.sv
// 3x3 valid convolution of a 4x4 unsigned matrix, built as a chain of nine
// weight-stationary MAC elements. The four output windows stream through the
// chain one per cycle; a single operation runs after each reset release.
//   clk, rst                     : clock, synchronous active-high reset
//   mat_input11..mat_input44     : input matrix [row][col]
//   filter11..filter33           : filter coefficients [row][col]
//   done_3_3                     : all four results valid, held until reset
//   result11/12/21/22            : conv outputs, truncated to DATA_W bits
module systolic_array_3x3
    import systolic_array_3x3_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] mat_input11, mat_input12, mat_input13, mat_input14,
    input  logic [DATA_W-1:0] mat_input21, mat_input22, mat_input23, mat_input24,
    input  logic [DATA_W-1:0] mat_input31, mat_input32, mat_input33, mat_input34,
    input  logic [DATA_W-1:0] mat_input41, mat_input42, mat_input43, mat_input44,
    input  logic [DATA_W-1:0] filter11, filter12, filter13,
    input  logic [DATA_W-1:0] filter21, filter22, filter23,
    input  logic [DATA_W-1:0] filter31, filter32, filter33,
    output logic              done_3_3,
    output logic [DATA_W-1:0] result11,
    output logic [DATA_W-1:0] result12,
    output logic [DATA_W-1:0] result21,
    output logic [DATA_W-1:0] result22
);
    logic [N_MAT-1:0][DATA_W-1:0] mat_in, mat_q;
    logic [N_PE-1:0][DATA_W-1:0]  filt_in, x;
    logic [N_PE:0][ACC_W-1:0]     psum;
    logic [N_WIN-1:0][DATA_W-1:0] res;
    logic [CNT_W-1:0]             cnt;
    logic                         snap;

    // Index 0 is element [1][1]; both arrays are row-major.
    assign mat_in = {mat_input44, mat_input43, mat_input42, mat_input41,
                     mat_input34, mat_input33, mat_input32, mat_input31,
                     mat_input24, mat_input23, mat_input22, mat_input21,
                     mat_input14, mat_input13, mat_input12, mat_input11};
    assign filt_in = {filter33, filter32, filter31,
                      filter23, filter22, filter21,
                      filter13, filter12, filter11};

    // First edge after release captures every operand; later port activity
    // is ignored until the next reset.
    assign snap = (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            mat_q    <= '0;
            res      <= '0;
            done_3_3 <= 1'b0;
        end else begin
            if (cnt != DONE_CNT) cnt <= cnt + 1'b1;
            if (snap) mat_q <= mat_in;
            // Window w leaves PE 8 during cycle N_PE+1+w.
            for (int w = 0; w < N_WIN; w++)
                if (cnt == CNT_W'(N_PE + 1 + w)) res[w] <= psum[N_PE][DATA_W-1:0];
            if (cnt == DONE_CNT - 1'b1) done_3_3 <= 1'b1;
        end
    end

    // Operand skew: window w reaches PE k in cycle cnt = 1+w+k, so each PE
    // sees its four windows on consecutive cycles, diagonally offset.
    always_comb begin
        x = '0;
        for (int k = 0; k < N_PE; k++)
            for (int w = 0; w < N_WIN; w++)
                if (cnt == CNT_W'(1 + w + k)) x[k] = mat_q[WIN_MAP[w][k]];
    end

    assign psum[0] = '0;

    for (genvar k = 0; k < N_PE; k++) begin : g_pe
        systolic_pe u_pe (
            .clk      (clk),
            .rst      (rst),
            .load     (snap),
            .weight   (filt_in[k]),
            .x        (x[k]),
            .psum_in  (psum[k]),
            .psum_out (psum[k+1])
        );
    end

    assign result11 = res[0];
    assign result12 = res[1];
    assign result21 = res[2];
    assign result22 = res[3];
endmodule

// File: tb/tb_systolic_array_3x3.sv
module tb_systolic_array_3x3;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] mat_v  [16];
    logic [7:0] filt_v [9];
    logic       done_3_3;
    logic [7:0] result11, result12, result21, result22;

    int checks = 0;
    int errors = 0;
    int edges  = 0;
    logic done_seen = 1'b0;
    logic [31:0] exp_q [$];   // {r22, r21, r12, r11}

    int t1m [16] = '{2,1,3,1, 0,2,4,2, 1,3,2,0, 2,1,0,1};
    int t1f [9]  = '{1,0,1, 1,1,0, 0,1,1};

    always #5 clk = ~clk;

    systolic_array_3x3 dut (
        .clk(clk), .rst(rst),
        .mat_input11(mat_v[0]),  .mat_input12(mat_v[1]),  .mat_input13(mat_v[2]),  .mat_input14(mat_v[3]),
        .mat_input21(mat_v[4]),  .mat_input22(mat_v[5]),  .mat_input23(mat_v[6]),  .mat_input24(mat_v[7]),
        .mat_input31(mat_v[8]),  .mat_input32(mat_v[9]),  .mat_input33(mat_v[10]), .mat_input34(mat_v[11]),
        .mat_input41(mat_v[12]), .mat_input42(mat_v[13]), .mat_input43(mat_v[14]), .mat_input44(mat_v[15]),
        .filter11(filt_v[0]), .filter12(filt_v[1]), .filter13(filt_v[2]),
        .filter21(filt_v[3]), .filter22(filt_v[4]), .filter23(filt_v[5]),
        .filter31(filt_v[6]), .filter32(filt_v[7]), .filter33(filt_v[8]),
        .done_3_3(done_3_3),
        .result11(result11), .result12(result12), .result21(result21), .result22(result22)
    );

    // Edges since reset release; done must rise on edge 14.
    always @(posedge clk) edges <= rst ? 0 : edges + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: on each rising done, pop the expected results and compare.
    always @(negedge clk) begin
        if (done_3_3 && !done_seen) begin
            done_seen = 1'b1;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("result11", result11, e[7:0]);
                chk("result12", result12, e[15:8]);
                chk("result21", result21, e[23:16]);
                chk("result22", result22, e[31:24]);
                chk("done_edge", edges, 14);
            end
        end
        if (!done_3_3) done_seen = 1'b0;
    end

    // mode 0: directed case, 1: all 255, 2: center tap over 1..16,
    // 3: zero filter over 1..16, other: all zero
    task automatic set_ops(input int mode);
        for (int i = 0; i < 16; i++)
            case (mode)
                0:       mat_v[i] = 8'(t1m[i]);
                1:       mat_v[i] = 8'd255;
                2, 3:    mat_v[i] = 8'(i + 1);
                default: mat_v[i] = 8'd0;
            endcase
        for (int i = 0; i < 9; i++)
            case (mode)
                0:       filt_v[i] = 8'(t1f[i]);
                1:       filt_v[i] = 8'd255;
                2:       filt_v[i] = (i == 4) ? 8'd1 : 8'd0;
                default: filt_v[i] = 8'd0;
            endcase
    endtask

    task automatic check_zero(input string name);
        chk({name, "_r11"}, result11, 0);
        chk({name, "_r12"}, result12, 0);
        chk({name, "_r21"}, result21, 0);
        chk({name, "_r22"}, result22, 0);
        chk({name, "_done"}, done_3_3, 0);
    endtask

    // Called just after a posedge; the next posedge is edge 1.
    task automatic start_run(input int r11, r12, r21, r22);
        exp_q.push_back({8'(r22), 8'(r21), 8'(r12), 8'(r11)});
        rst = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            chk({name, "_timeout"}, 1, 0);
            exp_q.delete();
        end
    endtask

    task automatic do_reset(input string name);
        rst = 1'b1;
        @(posedge clk); #1;
        check_zero(name);
    endtask

    initial begin
        set_ops(4);
        repeat (2) @(posedge clk);
        #1 check_zero("reset");

        // directed case; done must still be low after edge 13
        set_ops(0);
        start_run(12, 10, 9, 10);
        repeat (13) @(posedge clk);
        #1 chk("done_edge13", done_3_3, 0);
        wait_done("case_directed");
        do_reset("clear_after_done");

        // truncation of 585225 to 8 bits
        set_ops(1);
        @(posedge clk); #1;
        start_run(9, 9, 9, 9);
        wait_done("case_255");
        do_reset("reset2");

        // center tap only picks the middle 2x2 of the input
        set_ops(2);
        @(posedge clk); #1;
        start_run(6, 7, 10, 11);
        wait_done("case_center");
        do_reset("reset3");

        // operands zeroed after edge 3 must not disturb the snapshot
        set_ops(0);
        @(posedge clk); #1;
        start_run(12, 10, 9, 10);
        repeat (3) @(posedge clk);
        #1 set_ops(4);
        wait_done("case_snapshot");
        do_reset("reset4");

        // abort at cnt=6 with all-255 operands, restart with fresh ones
        set_ops(1);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1 set_ops(2);
        do_reset("abort");
        start_run(6, 7, 10, 11);
        wait_done("case_restart");
        do_reset("reset5");

        // zero filter, then hold reset and confirm outputs stay clear
        set_ops(3);
        @(posedge clk); #1;
        start_run(0, 0, 0, 0);
        wait_done("case_zero_filter");
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1 check_zero("hold");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
